// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue and HI/LO write-back bus between EX and the mul/div unit
interface muldiv_unit_if #(parameter int DW = 32);
   logic          start;
   logic [2:0]    op;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic          flush;
   logic          busy;
   logic          cs_hi;
   logic          cs_lo;
   logic [DW-1:0] WHIdata;
   logic [DW-1:0] WLOdata;

   modport master (
      output start, op, opa, opb, flush,
      input  busy, cs_hi, cs_lo, WHIdata, WLOdata
   );

   modport slave (
      input  start, op, opa, opb, flush,
      output busy, cs_hi, cs_lo, WHIdata, WLOdata
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO engine driving the HI/LO write port; MULDIV_FAST_MUL_EN selects a single-cycle array multiply
module muldiv_unit #(
   parameter int            DW      = 32,
   parameter logic [DW-1:0] DIV0_LO = {DW{1'b1}}
) (
   input logic           clk,
   input logic           rst,
   muldiv_unit_if.slave  bus
);
   localparam int CW = $clog2(DW);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] acc_hi;     // mul: upper partial product; div: remainder
   logic [DW-1:0] acc_lo;     // mul: multiplier / lower product; div: dividend / quotient
   logic [DW-1:0] mag_r;      // latched multiplicand or divisor magnitude
   logic          is_div;
   logic          div0;
   logic          neg_res;    // negate product (MULT) or quotient (DIV)
   logic          neg_rem;    // remainder takes the dividend's sign
   logic          cs_hi_r;
   logic          cs_lo_r;
   logic [DW-1:0] hi_data;
   logic [DW-1:0] lo_data;

   logic          sgn_op;
   logic          sa;
   logic          sb;
   logic [DW-1:0] mag_a;
   logic [DW-1:0] mag_b;
   logic          go;
   logic [DW:0]   mul_sum;
   logic [DW:0]   div_shift;
   logic [DW:0]   div_trial;
   logic          div_take;
   logic [2*DW-1:0] prod;
   logic [2*DW-1:0] prod_s;
   logic [DW-1:0] quo_s;
   logic [DW-1:0] rem_s;
   logic [DW-1:0] fix_hi;
   logic [DW-1:0] fix_lo;

   assign sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign sa     = sgn_op & bus.opa[DW-1];
   assign sb     = sgn_op & bus.opb[DW-1];
   assign mag_a  = sa ? -bus.opa : bus.opa;
   assign mag_b  = sb ? -bus.opb : bus.opb;
   assign go     = bus.start && !bus.flush;

   // one radix-2 step: shift-add for multiply, compare-subtract for divide
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_r} : {(DW+1){1'b0}});
   assign div_shift = {acc_hi, acc_lo[DW-1]};
   assign div_trial = div_shift - {1'b0, mag_r};
   assign div_take  = !div_trial[DW];

   // sign fix-up applied while in FIX
   assign prod   = {acc_hi, acc_lo};
   assign prod_s = neg_res ? -prod : prod;
   assign quo_s  = neg_res ? -acc_lo : acc_lo;
   assign rem_s  = neg_rem ? -acc_hi : acc_hi;
   assign fix_hi = div0 ? acc_hi  : (is_div ? rem_s : prod_s[2*DW-1:DW]);
   assign fix_lo = div0 ? DIV0_LO : (is_div ? quo_s : prod_s[DW-1:0]);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*DW-1:0] fast_prod;
   assign fast_prod = {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
`endif

   assign bus.busy    = (state != S_IDLE);
   assign bus.cs_hi   = cs_hi_r;
   assign bus.cs_lo   = cs_lo_r;
   assign bus.WHIdata = hi_data;
   assign bus.WLOdata = lo_data;

   // FSM, iterative datapath and registered HI/LO write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         mag_r   <= '0;
         is_div  <= 1'b0;
         div0    <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         cs_hi_r <= 1'b0;
         cs_lo_r <= 1'b0;
         hi_data <= '0;
         lo_data <= '0;
      end else begin
         cs_hi_r <= 1'b0;
         cs_lo_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  case (bus.op)
                     OP_MTHI: begin
                        cs_hi_r <= 1'b1;
                        hi_data <= bus.opa;
                     end
                     OP_MTLO: begin
                        cs_lo_r <= 1'b1;
                        lo_data <= bus.opa;
                     end
                     OP_MULT, OP_MULTU: begin
                        is_div  <= 1'b0;
                        div0    <= 1'b0;
                        neg_res <= sa ^ sb;
                        neg_rem <= 1'b0;
                        mag_r   <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
                        acc_hi  <= fast_prod[2*DW-1:DW];
                        acc_lo  <= fast_prod[DW-1:0];
                        state   <= S_FIX;
`else
                        acc_hi  <= '0;
                        acc_lo  <= mag_b;
                        cnt     <= CW'(DW-1);
                        state   <= S_RUN;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        is_div  <= 1'b1;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        mag_r   <= mag_b;
                        if (bus.opb == '0) begin
                           div0   <= 1'b1;
                           acc_hi <= bus.opa;
                           state  <= S_FIX;
                        end else begin
                           div0   <= 1'b0;
                           acc_hi <= '0;
                           acc_lo <= mag_a;
                           cnt    <= CW'(DW-1);
                           state  <= S_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  state <= S_IDLE;
               end else begin
                  if (is_div) begin
                     acc_hi <= div_take ? div_trial[DW-1:0] : div_shift[DW-1:0];
                     acc_lo <= {acc_lo[DW-2:0], div_take};
                  end else begin
                     acc_hi <= mul_sum[DW:1];
                     acc_lo <= {mul_sum[0], acc_lo[DW-1:1]};
                  end
                  if (cnt == '0) state <= S_FIX;
                  else cnt <= cnt - 1'b1;
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               if (!bus.flush) begin
                  cs_hi_r <= 1'b1;
                  cs_lo_r <= 1'b1;
                  hi_data <= fix_hi;
                  lo_data <= fix_lo;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
   typedef struct {
      logic [2:0]  op;
      logic        hi_en;
      logic        lo_en;
      logic [31:0] hi;
      logic [31:0] lo;
      int          issue;
      int          lat;
   } exp_t;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cyc;
   logic [31:0] last_hi;
   logic [31:0] last_lo;
   exp_t sb_q[$];

   muldiv_unit_if bus_i ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] p;
      int sa;
      int sb;
      e.op = op; e.hi_en = 1'b1; e.lo_en = 1'b1; e.hi = '0; e.lo = '0; e.issue = 0; e.lat = 34;
      sa = a;
      sb = b;
      case (op)
         3'b100: begin e.lo_en = 1'b0; e.hi = a; e.lat = 1; end
         3'b101: begin e.hi_en = 1'b0; e.lo = a; e.lat = 1; end
         3'b000, 3'b001: begin
            if (op == 3'b000) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else              p = {32'h0, a} * {32'h0, b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
         end
         default: begin
            if (b == 32'h0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = 2;
            end else if (op == 3'b011) begin
               e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 32'h0;
            end else begin
               e.lo = sa / sb; e.hi = sa % sb;
            end
         end
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // advance one cycle; sample at negedge and score any HI/LO write
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (rst) begin
         last_hi = '0;
         last_lo = '0;
      end
      if (bus_i.cs_hi || bus_i.cs_lo) begin
         if (sb_q.size() == 0) begin
            check("unexpected_cs", {62'h0, bus_i.cs_hi, bus_i.cs_lo}, 64'h0);
         end else begin
            e = sb_q.pop_front();
            if (e.hi_en) last_hi = e.hi;
            if (e.lo_en) last_lo = e.lo;
            check($sformatf("op%0d_cs_hi", e.op), {63'h0, bus_i.cs_hi}, {63'h0, e.hi_en});
            check($sformatf("op%0d_cs_lo", e.op), {63'h0, bus_i.cs_lo}, {63'h0, e.lo_en});
            check($sformatf("op%0d_latency", e.op), 64'(cyc - e.issue), 64'(e.lat));
            check($sformatf("op%0d_hi", e.op), {32'h0, bus_i.WHIdata}, {32'h0, last_hi});
            check($sformatf("op%0d_lo", e.op), {32'h0, bus_i.WLOdata}, {32'h0, last_lo});
         end
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      bus_i.start = 1'b1;
      bus_i.op    = op;
      bus_i.opa   = a;
      bus_i.opb   = b;
      if (push) begin
         e = model(op, a, b);
         e.issue = cyc;
         sb_q.push_back(e);
      end
      tick();
      bus_i.start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || bus_i.busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         check("drain_timeout", 64'(n), 64'(budget - 1));
         sb_q.delete();
      end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      last_hi = '0; last_lo = '0;
      rst = 1'b1;
      bus_i.start = 1'b0; bus_i.op = 3'b111; bus_i.opa = '0; bus_i.opb = '0; bus_i.flush = 1'b0;
      repeat (3) tick();
      check("reset_busy", {63'h0, bus_i.busy}, 64'h0);
      check("reset_cs", {62'h0, bus_i.cs_hi, bus_i.cs_lo}, 64'h0);
      check("reset_whi", {32'h0, bus_i.WHIdata}, 64'h0);
      check("reset_wlo", {32'h0, bus_i.WLOdata}, 64'h0);
      rst = 1'b0;
      tick();

      send(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      check("mul_busy", {63'h0, bus_i.busy}, 64'h1);
      drain(100);
      send(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
      drain(100);
      send(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      drain(100);

      // divide-by-zero: busy for exactly one cycle
      send(3'b011, 32'h0000_1234, 32'h0, 1'b1);
      check("div0_busy_1", {63'h0, bus_i.busy}, 64'h1);
      tick();
      check("div0_busy_2", {63'h0, bus_i.busy}, 64'h0);
      drain(10);

      send(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain(100);
      send(3'b010, 32'h0000_0000, 32'h0000_0000, 1'b1);
      drain(10);

      for (int i = 0; i < 8; i++) begin
         send(3'($urandom_range(0, 3)), $urandom, (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)), 1'b1);
         drain(100);
      end

      // MTHI leaves LO untouched
      send(3'b100, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1);
      drain(10);

      // MTLO held while a DIV runs is ignored, then reissued
      send(3'b010, 32'd100, 32'd7, 1'b1);
      bus_i.start = 1'b1; bus_i.op = 3'b101; bus_i.opa = 32'hA5A5_A5A5; bus_i.opb = 32'h0;
      repeat (10) tick();
      bus_i.start = 1'b0;
      drain(100);
      send(3'b101, 32'hA5A5_A5A5, 32'h0, 1'b1);
      drain(10);

      // back-to-back: new start accepted in the cs cycle
      send(3'b011, 32'h0000_0005, 32'h0, 1'b1);
      tick();
      send(3'b100, 32'h0BAD_F00D, 32'h0, 1'b1);
      drain(10);

      // flush mid-RUN: no write, busy drops next edge
      send(3'b011, 32'd100, 32'd7, 1'b0);
      repeat (9) tick();
      bus_i.flush = 1'b1;
      tick();
      bus_i.flush = 1'b0;
      check("flush_busy", {63'h0, bus_i.busy}, 64'h0);
      repeat (40) tick();
      send(3'b001, 32'd6, 32'd7, 1'b1);
      drain(100);

      // rst mid-RUN: same outcome, registers cleared
      send(3'b011, 32'd100, 32'd7, 1'b0);
      repeat (9) tick();
      rst = 1'b1;
      bus_i.flush = 1'b1;
      tick();
      rst = 1'b0;
      bus_i.flush = 1'b0;
      check("rst_busy", {63'h0, bus_i.busy}, 64'h0);
      check("rst_whi", {32'h0, bus_i.WHIdata}, 64'h0);
      repeat (40) tick();
      send(3'b001, 32'd6, 32'd7, 1'b1);
      drain(100);

      // flush on the start edge drops the start
      bus_i.flush = 1'b1;
      send(3'b011, 32'd50, 32'd3, 1'b0);
      bus_i.flush = 1'b0;
      check("flush_start_busy", {63'h0, bus_i.busy}, 64'h0);

      // flush while in FIX (divide-by-zero path)
      send(3'b011, 32'd50, 32'd0, 1'b0);
      bus_i.flush = 1'b1;
      tick();
      bus_i.flush = 1'b0;
      check("flush_fix_busy", {63'h0, bus_i.busy}, 64'h0);

      // 11x op is a no-op
      send(3'b110, 32'd1, 32'd1, 1'b0);
      check("nop_busy", {63'h0, bus_i.busy}, 64'h0);
      repeat (5) tick();
      check("final_whi", {32'h0, bus_i.WHIdata}, {32'h0, last_hi});
      check("final_wlo", {32'h0, bus_i.WLOdata}, {32'h0, last_lo});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
